// File: rtl/fsm_test_pkg.sv
// Shared definitions for the on-chip FSM vector sequencer: state encoding and vector bit layout.
package fsm_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int VEC_RST = 2;
  localparam int VEC_IN  = 1;
  localparam int VEC_EXP = 0;

endpackage

// File: rtl/fsm_vector_ram.sv
// DEPTH x 3 vector table: one write port with out-of-range drop, one combinational read port.
module fsm_vector_ram #(
  parameter int DEPTH = 13,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [2:0]    rdata
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [2:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fsm_vector_sequencer.sv
// Self-test controller: replays {reset,in,expected} vectors into an FSM under test and
// counts mismatches, recording the first failing slot.
module fsm_vector_sequencer
  import fsm_test_pkg::*;
#(
  parameter int DEPTH = 13,
  parameter int AW    = 4,
  parameter int EW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vec_we,
  input  logic [AW-1:0] vec_waddr,
  input  logic [2:0]    vec_wdata,
  input  logic [AW:0]   vec_count,
  input  logic          start,
  output logic          dut_reset,
  output logic          dut_in,
  input  logic          dut_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [EW-1:0] err_count,
  output logic          fail_valid,
  output logic [AW-1:0] fail_index
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          exp_q, exp_d;
  logic          dut_reset_q, dut_reset_d;
  logic          dut_in_q, dut_in_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [EW-1:0] err_q, err_d;
  logic          fail_valid_q, fail_valid_d;
  logic [AW-1:0] fail_index_q, fail_index_d;
  logic [2:0]    rd_vec_s;

  // Table writes are locked out for the whole run so the vectors cannot change underneath it.
  fsm_vector_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (vec_we && !busy_q),
    .waddr (vec_waddr),
    .wdata (vec_wdata),
    .raddr (idx_q),
    .rdata (rd_vec_s)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    exp_d        = exp_q;
    dut_reset_d  = dut_reset_q;
    dut_in_d     = dut_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_index_d = fail_index_q;
    case (state_q)
      ST_IDLE: begin
        dut_reset_d = 1'b1;
        dut_in_d    = 1'b0;
        if (start) begin
          len_d        = (vec_count > DEPTH_L) ? DEPTH_L : vec_count;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_index_d = '0;
          pass_d       = 1'b0;
          idx_d        = '0;
          if (len_d == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_APPLY;
            busy_d  = 1'b1;
          end
        end
      end
      ST_APPLY: begin
        dut_reset_d = rd_vec_s[VEC_RST];
        dut_in_d    = rd_vec_s[VEC_IN];
        exp_d       = rd_vec_s[VEC_EXP];
        state_d     = ST_CHECK;
      end
      ST_CHECK: begin
        if (dut_out != exp_q) begin
          if (err_q != '1) begin
            err_d = err_q + EW'(1);
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_index_d = idx_q;
          end
        end
        if ({1'b0, idx_q} == (len_q - (AW+1)'(1))) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          dut_reset_d = 1'b1;
          dut_in_d    = 1'b0;
          pass_d      = (err_d == '0);
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        dut_reset_d = 1'b1;
        dut_in_d    = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      exp_q        <= 1'b0;
      dut_reset_q  <= 1'b1;
      dut_in_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_index_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      exp_q        <= exp_d;
      dut_reset_q  <= dut_reset_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign dut_reset  = dut_reset_q;
  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_index = fail_index_q;

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Bench for fsm_vector_sequencer driving a 1-cycle delay FSM (out <= reset ? 0 : in).
module tb_fsm_vector_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vec_we = 1'b0;
  logic [3:0] vec_waddr = 4'd0;
  logic [2:0] vec_wdata = 3'd0;
  logic [4:0] vec_count = 5'd0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;

  logic       dut_reset1, dut_in1, dut_out1, busy1, done1, pass1, fail_valid1;
  logic [7:0] err_count1;
  logic [3:0] fail_index1;
  logic       dut_reset2, dut_in2, dut_out2, busy2, done2, pass2, fail_valid2;
  logic [1:0] err_count2;
  logic [3:0] fail_index2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_vector_sequencer #(.DEPTH(13), .AW(4), .EW(8)) u_dut (
    .clk(clk), .reset(reset), .vec_we(vec_we), .vec_waddr(vec_waddr), .vec_wdata(vec_wdata),
    .vec_count(vec_count), .start(start1), .dut_reset(dut_reset1), .dut_in(dut_in1),
    .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .fail_index(fail_index1)
  );

  fsm_vector_sequencer #(.DEPTH(13), .AW(4), .EW(2)) u_dut_sat (
    .clk(clk), .reset(reset), .vec_we(vec_we), .vec_waddr(vec_waddr), .vec_wdata(vec_wdata),
    .vec_count(vec_count), .start(start2), .dut_reset(dut_reset2), .dut_in(dut_in2),
    .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .fail_valid(fail_valid2), .fail_index(fail_index2)
  );

  // FSMs under test: one-cycle delay with synchronous clear.
  always_ff @(posedge clk) begin
    dut_out1 <= dut_reset1 ? 1'b0 : dut_in1;
    dut_out2 <= dut_reset2 ? 1'b0 : dut_in2;
  end

  // The compare at the end of vector i's CHECK sees the response to vector i-1 (the held drive
  // of the preceding APPLY cycle), so each expected bit follows the previous vector's {reset,in}.
  logic [2:0] gold [13];

  typedef struct {
    int   count;
    int   flip;
    logic exp_pass;
    int   exp_err;
    logic exp_fv;
    int   exp_fi;
    int   exp_cyc;
  } run_vec_t;

  run_vec_t runs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [2:0] data);
    @(negedge clk);
    vec_we    = 1'b1;
    vec_waddr = 4'(addr);
    vec_wdata = data;
    @(negedge clk);
    vec_we    = 1'b0;
  endtask

  task automatic load(input int flip);
    logic [2:0] d;
    for (int i = 0; i < 13; i++) begin
      d = gold[i];
      if (i == flip) d[0] = ~d[0];
      wr(i, d);
    end
  endtask

  // Starts a run and returns the cycle (start cycle = 0) in which done is first seen.
  task automatic run(input int which, input int count, input int inj_cyc,
                     input logic sim_we, input int sim_addr, input logic [2:0] sim_data,
                     output int cyc);
    @(negedge clk);
    vec_count = 5'(count);
    if (which == 1) start2 = 1'b1; else start1 = 1'b1;
    if (sim_we) begin
      vec_we    = 1'b1;
      vec_waddr = 4'(sim_addr);
      vec_wdata = sim_data;
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    vec_we = 1'b0;
    cyc = 1;
    while (((which == 1) ? done2 : done1) == 1'b0 && cyc < 100) begin
      if (cyc == inj_cyc) begin
        start1    = 1'b1;
        vec_we    = 1'b1;
        vec_waddr = 4'd3;
        vec_wdata = 3'b111;
      end
      @(negedge clk);
      start1 = 1'b0;
      vec_we = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    gold = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b010, 3'b011, 3'b111,
             3'b010, 3'b011, 3'b101, 3'b010, 3'b001, 3'b000};
    runs[0] = '{13, -1, 1'b1, 0, 1'b0, 0, 27};
    runs[1] = '{13,  5, 1'b0, 1, 1'b1, 5, 27};
    runs[2] = '{ 0, -1, 1'b1, 0, 1'b0, 0,  1};
    runs[3] = '{20, -1, 1'b1, 0, 1'b0, 0, 27};
    runs[4] = '{ 4,  5, 1'b1, 0, 1'b0, 0,  9};
    runs[5] = '{13,  2, 1'b0, 1, 1'b1, 2, 27};
    runs[6] = '{ 6,  5, 1'b0, 1, 1'b1, 5, 13};

    repeat (3) @(negedge clk);
    chk("rst_dut_reset", dut_reset1, 1);
    chk("rst_dut_in", dut_in1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err", err_count1, 0);
    chk("rst_fail_valid", fail_valid1, 0);
    chk("rst_fail_index", fail_index1, 0);
    reset = 1'b0;

    for (int r = 0; r < 7; r++) begin
      load(runs[r].flip);
      run(0, runs[r].count, -1, 1'b0, 0, 3'd0, cyc);
      chk($sformatf("run%0d_cycles", r), cyc, runs[r].exp_cyc);
      chk($sformatf("run%0d_pass", r), pass1, runs[r].exp_pass);
      chk($sformatf("run%0d_err", r), err_count1, runs[r].exp_err);
      chk($sformatf("run%0d_fail_valid", r), fail_valid1, runs[r].exp_fv);
      chk($sformatf("run%0d_fail_index", r), fail_index1, runs[r].exp_fi);
      chk($sformatf("run%0d_dut_reset", r), dut_reset1, 1);
      chk($sformatf("run%0d_busy", r), busy1, 0);
      @(negedge clk);
      chk($sformatf("run%0d_done_pulse", r), done1, 0);
      chk($sformatf("run%0d_pass_hold", r), pass1, runs[r].exp_pass);
    end

    // start and a slot-3 write mid-run must both be ignored.
    load(-1);
    run(0, 13, 5, 1'b0, 0, 3'd0, cyc);
    chk("busy_ign_cycles", cyc, 27);
    chk("busy_ign_pass", pass1, 1);
    run(0, 13, -1, 1'b0, 0, 3'd0, cyc);
    chk("busy_ign_table_pass", pass1, 1);
    chk("busy_ign_table_err", err_count1, 0);

    // Write in the start cycle lands before the run reads the table.
    run(0, 13, -1, 1'b1, 5, 3'b010, cyc);
    chk("same_cyc_err", err_count1, 1);
    chk("same_cyc_fail_index", fail_index1, 5);
    chk("same_cyc_pass", pass1, 0);

    // Out-of-range address is dropped.
    load(-1);
    wr(13, 3'b011);
    run(0, 13, -1, 1'b0, 0, 3'd0, cyc);
    chk("addr13_pass", pass1, 1);
    chk("addr13_err", err_count1, 0);

    // Reset during the 4th CHECK (cycle 8) abandons the run.
    load(1);
    @(negedge clk);
    vec_count = 5'd13;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst_err_before", err_count1, 1);
    chk("midrst_busy_before", busy1, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy1, 0);
    chk("midrst_dut_reset", dut_reset1, 1);
    chk("midrst_err", err_count1, 0);
    chk("midrst_fail_valid", fail_valid1, 0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1) cyc++;
    end
    chk("midrst_no_done", cyc, 0);

    // Saturation on the EW=2 instance: every vector mismatches.
    for (int i = 0; i < 13; i++) wr(i, 3'b101);
    run(1, 13, -1, 1'b0, 0, 3'd0, cyc);
    chk("sat_cycles", cyc, 27);
    chk("sat_err", err_count2, 3);
    chk("sat_fail_valid", fail_valid2, 1);
    chk("sat_fail_index", fail_index2, 0);
    chk("sat_pass", pass2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
